rs_issue_queue: RTL

Parametrised, age-ordered reservation station for the out-of-order core. It sits between rename/dispatch and the functional units. It accepts up to two renamed instructions per cycle and captures operands woken by NUM_WB writeback broadcast ports. Each cycle it issues the oldest ready instruction per functional unit, one per FU, under a valid/ready handshake.

---
 rtl/rs_issue_queue.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/rs_issue_queue.sv
// Age-ordered reservation station: two-wide dispatch, NUM_WB wakeup ports and
// oldest-ready selection per functional unit under a valid/ready handshake.
module rs_issue_queue #(
  parameter int DEPTH  = 16,
  parameter int NUM_FU = 3,
  parameter int NUM_WB = 2,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32,
  parameter int ROB_W  = 4,
  parameter int OP_W   = 8,
  localparam int FU_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic [1:0]                 disp_valid,
  output logic                       disp_ready,
  input  logic [2*OP_W-1:0]          disp_op,
  input  logic [2*FU_W-1:0]          disp_fu,
  input  logic [2*TAG_W-1:0]         disp_src1_tag,
  input  logic [2*TAG_W-1:0]         disp_src2_tag,
  input  logic [1:0]                 disp_src1_rdy,
  input  logic [1:0]                 disp_src2_rdy,
  input  logic [2*DATA_W-1:0]        disp_src1_val,
  input  logic [2*DATA_W-1:0]        disp_src2_val,
  input  logic [2*TAG_W-1:0]         disp_dst_tag,
  input  logic [2*ROB_W-1:0]         disp_rob_idx,
  input  logic [NUM_WB-1:0]          wb_valid,
  input  logic [NUM_WB*TAG_W-1:0]    wb_tag,
  input  logic [NUM_WB*DATA_W-1:0]   wb_val,
  input  logic [NUM_FU-1:0]          fu_ready,
  output logic [NUM_FU-1:0]          iss_valid,
  output logic [NUM_FU*OP_W-1:0]     iss_op,
  output logic [NUM_FU*DATA_W-1:0]   iss_src1_val,
  output logic [NUM_FU*DATA_W-1:0]   iss_src2_val,
  output logic [NUM_FU*TAG_W-1:0]    iss_dst_tag,
  output logic [NUM_FU*ROB_W-1:0]    iss_rob_idx,
  output logic [CNT_W-1:0]           rs_count
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0]  valid, src1Rdy, src2Rdy;
  logic [OP_W-1:0]   op      [DEPTH];
  logic [FU_W-1:0]   fu      [DEPTH];
  logic [TAG_W-1:0]  src1Tag [DEPTH];
  logic [TAG_W-1:0]  src2Tag [DEPTH];
  logic [TAG_W-1:0]  dstTag  [DEPTH];
  logic [DATA_W-1:0] src1Val [DEPTH];
  logic [DATA_W-1:0] src2Val [DEPTH];
  logic [ROB_W-1:0]  robIdx  [DEPTH];
  logic [DEPTH-1:0]  older     [DEPTH];
  logic [DEPTH-1:0]  olderNext [DEPTH];
  logic [CNT_W-1:0]  rsCount;

  logic [IDX_W-1:0]  freeIdx0, freeIdx1;
  logic [IDX_W-1:0]  allocIdx [2];
  logic [1:0]        allocEn;
  logic [DEPTH-1:0]  allocMask;
  logic [CNT_W-1:0]  allocCnt;
  logic              dispFire;

  logic [1:0]        dRdy1, dRdy2;
  logic [DATA_W-1:0] dVal1 [2];
  logic [DATA_W-1:0] dVal2 [2];
  logic [DEPTH-1:0]  wake1, wake2;
  logic [DATA_W-1:0] wakeVal1 [DEPTH];
  logic [DATA_W-1:0] wakeVal2 [DEPTH];

  logic [DEPTH-1:0]  cand [NUM_FU];
  logic [DEPTH-1:0]  sel  [NUM_FU];
  logic [IDX_W-1:0]  selIdx [NUM_FU];
  logic [DEPTH-1:0]  issueFree;
  logic [CNT_W-1:0]  issueCnt;

  assign rs_count   = rsCount;
  assign disp_ready = (rsCount <= CNT_W'(DEPTH - 2));
  assign dispFire   = disp_ready && !flush;

  // Two lowest free indices; disp_ready guarantees both exist when used
  always_comb begin
    freeIdx0 = '0;
    freeIdx1 = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!valid[i]) freeIdx0 = IDX_W'(i);
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!valid[i] && (IDX_W'(i) != freeIdx0)) freeIdx1 = IDX_W'(i);
  end

  always_comb begin
    allocEn[0]  = dispFire && disp_valid[0];
    allocEn[1]  = dispFire && disp_valid[1];
    allocIdx[0] = freeIdx0;
    allocIdx[1] = disp_valid[0] ? freeIdx1 : freeIdx0;
    allocMask   = '0;
    if (allocEn[0]) allocMask[allocIdx[0]] = 1'b1;
    if (allocEn[1]) allocMask[allocIdx[1]] = 1'b1;
    allocCnt = CNT_W'(allocEn[0]) + CNT_W'(allocEn[1]);
  end

  // Same-cycle broadcast bypass for dispatching sources; port 0 has priority
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      dRdy1[s] = disp_src1_rdy[s];
      dRdy2[s] = disp_src2_rdy[s];
      dVal1[s] = disp_src1_val[s*DATA_W +: DATA_W];
      dVal2[s] = disp_src2_val[s*DATA_W +: DATA_W];
      for (int w = NUM_WB - 1; w >= 0; w--) begin
        if (!disp_src1_rdy[s] && wb_valid[w] &&
            (wb_tag[w*TAG_W +: TAG_W] == disp_src1_tag[s*TAG_W +: TAG_W])) begin
          dRdy1[s] = 1'b1;
          dVal1[s] = wb_val[w*DATA_W +: DATA_W];
        end
        if (!disp_src2_rdy[s] && wb_valid[w] &&
            (wb_tag[w*TAG_W +: TAG_W] == disp_src2_tag[s*TAG_W +: TAG_W])) begin
          dRdy2[s] = 1'b1;
          dVal2[s] = wb_val[w*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wake1[i]    = 1'b0;
      wake2[i]    = 1'b0;
      wakeVal1[i] = src1Val[i];
      wakeVal2[i] = src2Val[i];
      for (int w = NUM_WB - 1; w >= 0; w--) begin
        if (valid[i] && !src1Rdy[i] && wb_valid[w] &&
            (wb_tag[w*TAG_W +: TAG_W] == src1Tag[i])) begin
          wake1[i]    = 1'b1;
          wakeVal1[i] = wb_val[w*DATA_W +: DATA_W];
        end
        if (valid[i] && !src2Rdy[i] && wb_valid[w] &&
            (wb_tag[w*TAG_W +: TAG_W] == src2Tag[i])) begin
          wake2[i]    = 1'b1;
          wakeVal2[i] = wb_val[w*DATA_W +: DATA_W];
        end
      end
    end
  end

  // A candidate is selected when no other candidate of its FU is older
  always_comb begin
    for (int f = 0; f < NUM_FU; f++) begin
      for (int i = 0; i < DEPTH; i++)
        cand[f][i] = valid[i] && (fu[i] == FU_W'(f)) && src1Rdy[i] && src2Rdy[i];
      for (int i = 0; i < DEPTH; i++) begin
        sel[f][i] = cand[f][i];
        for (int j = 0; j < DEPTH; j++)
          if (cand[f][j] && older[j][i]) sel[f][i] = 1'b0;
      end
      selIdx[f] = '0;
      for (int i = 0; i < DEPTH; i++)
        if (sel[f][i]) selIdx[f] = IDX_W'(i);
    end
  end

  always_comb begin
    iss_valid    = '0;
    iss_op       = '0;
    iss_src1_val = '0;
    iss_src2_val = '0;
    iss_dst_tag  = '0;
    iss_rob_idx  = '0;
    issueFree    = '0;
    issueCnt     = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      iss_valid[f]                     = |cand[f];
      iss_op[f*OP_W +: OP_W]           = op[selIdx[f]];
      iss_src1_val[f*DATA_W +: DATA_W] = src1Val[selIdx[f]];
      iss_src2_val[f*DATA_W +: DATA_W] = src2Val[selIdx[f]];
      iss_dst_tag[f*TAG_W +: TAG_W]    = dstTag[selIdx[f]];
      iss_rob_idx[f*ROB_W +: ROB_W]    = robIdx[selIdx[f]];
      if (iss_valid[f] && fu_ready[f]) begin
        issueFree = issueFree | sel[f];
        issueCnt  = issueCnt + CNT_W'(1);
      end
    end
  end

  // New entries are younger than every live entry; slot 0 beats slot 1
  always_comb begin
    for (int j = 0; j < DEPTH; j++) olderNext[j] = older[j];
    if (allocEn[0]) olderNext[allocIdx[0]] = '0;
    if (allocEn[1]) olderNext[allocIdx[1]] = '0;
    for (int j = 0; j < DEPTH; j++) begin
      if (allocEn[0]) olderNext[j][allocIdx[0]] = valid[j];
      if (allocEn[1])
        olderNext[j][allocIdx[1]] = valid[j] ||
                                    (allocEn[0] && (allocIdx[0] == IDX_W'(j)));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid   <= '0;
      rsCount <= '0;
      for (int j = 0; j < DEPTH; j++) older[j] <= '0;
    end else if (flush) begin
      valid   <= '0;
      rsCount <= '0;
    end else begin
      valid   <= (valid & ~issueFree) | allocMask;
      rsCount <= rsCount + allocCnt - issueCnt;
      for (int j = 0; j < DEPTH; j++) older[j] <= olderNext[j];
    end
  end

  // Payload storage needs no reset; valid gates every use of it
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wake1[i]) begin
        src1Rdy[i] <= 1'b1;
        src1Val[i] <= wakeVal1[i];
      end
      if (wake2[i]) begin
        src2Rdy[i] <= 1'b1;
        src2Val[i] <= wakeVal2[i];
      end
    end
    for (int s = 0; s < 2; s++) begin
      if (allocEn[s]) begin
        op[allocIdx[s]]      <= disp_op[s*OP_W +: OP_W];
        fu[allocIdx[s]]      <= disp_fu[s*FU_W +: FU_W];
        src1Tag[allocIdx[s]] <= disp_src1_tag[s*TAG_W +: TAG_W];
        src2Tag[allocIdx[s]] <= disp_src2_tag[s*TAG_W +: TAG_W];
        src1Rdy[allocIdx[s]] <= dRdy1[s];
        src2Rdy[allocIdx[s]] <= dRdy2[s];
        src1Val[allocIdx[s]] <= dVal1[s];
        src2Val[allocIdx[s]] <= dVal2[s];
        dstTag[allocIdx[s]]  <= disp_dst_tag[s*TAG_W +: TAG_W];
        robIdx[allocIdx[s]]  <= disp_rob_idx[s*ROB_W +: ROB_W];
      end
    end
  end

endmodule
